calc_port_responder: RTL and testbench
======================================

CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 Parameter LAT, default 2, SHALL set the cycles from the operand-2 cycle to the response cycle; legal range 1..8.
REQ-002 c_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_cmd_in  in  4  SHALL carry the command, in the defs encoding: NOP, ADD, SUB, LSH, RSH.
REQ-005 req_data_in  in  32  SHALL carry operand 1 in the command cycle and operand 2 in the following cycle.
REQ-006 req_tag_in  in  2  SHALL carry the request tag, sampled in the command cycle only.
REQ-007 out_resp  out  2  SHALL carry the response code: NORE, GOOD, INVL or ERR.
REQ-008 out_data  out  32  SHALL carry the result; 0 unless out_resp is GOOD.
REQ-009 out_tag  out  2  SHALL echo the request tag; 0 when out_resp is NORE.

Function
REQ-010 Request FSM SHALL have states IDLE and OP2; reset state is IDLE.
REQ-011 In IDLE with req_cmd_in != NOP: SHALL latch cmd, tag and operand 1, then go to OP2.
REQ-012 In IDLE with req_cmd_in == NOP: SHALL stay in IDLE.
REQ-013 In OP2: SHALL capture operand 2, compute the result, push one entry to the response queue, and return to IDLE.
REQ-014 In OP2: req_cmd_in and req_tag_in SHALL be ignored; a command cycle can therefore follow immediately (back-to-back every 2 cycles).
REQ-015 Data SHALL be treated as unsigned 32-bit, regardless of the package data type.
REQ-016 ADD: op1+op2 → GOOD; if there is a carry out of bit 31 → INVL, data 0.
REQ-017 SUB: op1-op2 → GOOD; if op2 > op1 → INVL, data 0.
REQ-018 SUB with op1 == op2 SHALL give GOOD, data 0.
REQ-019 LSH: op1 << op2[4:0] → GOOD; RSH: op1 >> op2[4:0] (logical) → GOOD.
REQ-020 LSH/RSH: op2[31:5] SHALL be ignored; bits shifted out SHALL be discarded without error.
REQ-021 Any other non-NOP command SHALL still consume two cycles and give INVL, data 0.
REQ-022 If the new tag equals the tag of an entry still pending in the queue: the new entry SHALL complete with ERR, data 0; the earlier entry SHALL be unaffected.
REQ-023 Response queue: 4 entries, FIFO order; each entry holds resp, data, tag and a down-counter loaded with LAT-1.
REQ-024 Counters of all valid entries SHALL decrement every cycle.
REQ-025 When the head counter reaches 0, the head SHALL drive the registered outputs for exactly one cycle and then be popped.
REQ-026 Latency: operand 2 presented in cycle k SHALL give the response visible in cycle k+LAT.
REQ-027 At most one response per cycle; the 2-cycle issue spacing with a fixed LAT guarantees no collision.
REQ-028 Queue overflow SHALL be unreachable for LAT ≤ 8 (at most 4 outstanding); an assertion SHALL flag a push while full.
REQ-029 Simultaneous push and pop in one cycle SHALL be supported without loss.
REQ-030 Outputs SHALL return to 0 in every cycle without a response.

Reset
REQ-031 While reset is high at a clock edge: FSM → IDLE, queue emptied, out_resp/out_data/out_tag → 0.
REQ-032 Pending responses SHALL be discarded silently; none SHALL appear after reset.
REQ-033 Reset asserted mid-request (in OP2) SHALL abort the request; no response SHALL be produced for it.
REQ-034 A command presented while reset is high SHALL be ignored; the first cycle with reset low SHALL be accepted.

Structure
REQ-035 The shared defs package SHALL hold: command encodings, response codes, all width parameters and typedefs, plus a new packed queue-entry typedef (resp, data, tag, count).
REQ-036 Combinational result/response computation SHALL be a sub-module, calc_resp_alu (inputs cmd, op1, op2; outputs resp, data).
REQ-037 The FSM, queue and duplicate-tag check SHALL stay in calc_port_responder.

Verification
REQ-038 LAT=2: ADD tag1, 5 then 7 → in cycle k+2: GOOD, data 12, tag 1; NORE in all other cycles.
REQ-039 ADD 0xFFFFFFFF + 1 → INVL, data 0; SUB 3-5 → INVL, data 0; SUB 5-5 → GOOD, data 0.
REQ-040 LSH 0x1, op2 0x21 → GOOD, 0x2; RSH 0x80000000, op2 31 → GOOD, 0x1; cmd 4'b1111 → INVL, data 0.
REQ-041 LAT=8: four back-to-back requests, tags 0,1,2,3 → four responses in order, spaced 2 cycles apart; no assertion fires.
REQ-042 LAT=4: tag2 ADD, then tag2 SUB issued 2 cycles later → first GOOD with correct sum, second ERR, tag 2.
REQ-043 Issue ADD, assert reset for 1 cycle during OP2, then issue ADD 1+1 tag3 → only GOOD 2, tag 3 is observed.

Source files
------------

// File: rtl/calc_port_responder_pkg.sv
// Shared definitions for the calculator port responder: encodings, widths
// and the packed response-queue entry.
package calc_port_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int TAG_W  = 2;
  localparam int RESP_W = 2;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_LSH = 4'd5,
    CMD_RSH = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NORE = 2'd0,
    RESP_GOOD = 2'd1,
    RESP_INVL = 2'd2,
    RESP_ERR  = 2'd3
  } resp_e;

  typedef struct packed {
    resp_e resp;
    data_t data;
    tag_t  tag;
    cnt_t  count;
  } q_entry_t;

endpackage

// File: rtl/calc_port_responder_alu.sv
// Combinational result and response-code computation for one request.
module calc_resp_alu
  import calc_port_responder_pkg::*;
(
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [RESP_W-1:0] resp,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, op1} + {1'b0, op2};

  // Anything that is not a recognised operation, or overflows, is INVL with zero data.
  always_comb begin
    resp = RESP_INVL;
    data = '0;
    case (cmd_e'(cmd))
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          resp = RESP_GOOD;
          data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp = RESP_GOOD;
          data = op1 - op2;
        end
      end
      CMD_LSH: begin
        resp = RESP_GOOD;
        data = op1 << op2[4:0];
      end
      CMD_RSH: begin
        resp = RESP_GOOD;
        data = op1 >> op2[4:0];
      end
      default: begin
        resp = RESP_INVL;
        data = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle request port with a fixed-latency response queue and
// duplicate-tag detection against responses still in flight.
module calc_port_responder
  import calc_port_responder_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic [RESP_W-1:0] out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic {ST_IDLE, ST_OP2} state_e;

  state_e            state;
  logic [CMD_W-1:0]  cmd_q;
  data_t             op1_q;
  tag_t              tag_q;

  q_entry_t          q      [QDEPTH];
  q_entry_t          q_next [QDEPTH];
  logic [2:0]        q_cnt;
  logic [2:0]        q_cnt_next;

  logic              push;
  logic              pop;
  logic              dup;
  logic [RESP_W-1:0] alu_resp;
  data_t             alu_data;
  q_entry_t          new_entry;

  calc_resp_alu u_alu (
    .cmd  (cmd_q),
    .op1  (op1_q),
    .op2  (req_data_in),
    .resp (alu_resp),
    .data (alu_data)
  );

  assign push = (state == ST_OP2);
  assign pop  = (q_cnt != 3'd0) && (q[0].count == '0);

  // The head being popped this cycle has already completed, so it no longer blocks its tag.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if ((3'(i) < q_cnt) && !((i == 0) && pop) && (q[i].tag == tag_q)) begin
        dup = 1'b1;
      end
    end
  end

  always_comb begin
    new_entry.resp  = dup ? RESP_ERR : resp_e'(alu_resp);
    new_entry.data  = dup ? '0 : alu_data;
    new_entry.tag   = tag_q;
    new_entry.count = CNT_W'(LAT - 1);
  end

  // Age every entry, shift out the head on pop, then append the new entry behind the survivors.
  always_comb begin
    q_next     = q;
    q_cnt_next = q_cnt;
    for (int i = 0; i < QDEPTH; i++) begin
      if ((3'(i) < q_cnt) && (q[i].count != '0)) begin
        q_next[i].count = q[i].count - 1'b1;
      end
    end
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        q_next[i] = q_next[i+1];
      end
      q_next[QDEPTH-1] = '0;
      q_cnt_next       = q_cnt - 3'd1;
    end
    if (push) begin
      q_next[q_cnt_next[1:0]] = new_entry;
      q_cnt_next              = q_cnt_next + 3'd1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      op1_q    <= '0;
      tag_q    <= '0;
      q_cnt    <= '0;
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      assert (!(push && (q_cnt == 3'(QDEPTH)) && !pop));
      case (state)
        ST_IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            tag_q <= req_tag_in;
            state <= ST_OP2;
          end
        end
        ST_OP2: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      q     <= q_next;
      q_cnt <= q_cnt_next;
      if (pop) begin
        out_resp <= q[0].resp;
        out_data <= q[0].data;
        out_tag  <= q[0].tag;
      end else begin
        out_resp <= '0;
        out_data <= '0;
        out_tag  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder: three latency variants driven in parallel,
// checked every cycle against a cycle-indexed table of expected responses.
module tb_calc_port_responder;
  import calc_port_responder_pkg::*;

  localparam int NDUT = 3;
  localparam int MAXC = 1024;
  localparam int LATS [NDUT] = '{2, 8, 4};

  logic        c_clk;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  o_resp [NDUT];
  logic [31:0] o_data [NDUT];
  logic [1:0]  o_tag  [NDUT];

  logic [1:0]  exp_resp [NDUT][MAXC];
  logic [31:0] exp_data [NDUT][MAXC];
  logic [1:0]  exp_tag  [NDUT][MAXC];

  int cyc;
  int checks;
  int errors;

  calc_port_responder #(.LAT(2)) u_lat2 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .out_resp(o_resp[0]), .out_data(o_data[0]), .out_tag(o_tag[0]));
  calc_port_responder #(.LAT(8)) u_lat8 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .out_resp(o_resp[1]), .out_data(o_data[1]), .out_tag(o_tag[1]));
  calc_port_responder #(.LAT(4)) u_lat4 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .out_resp(o_resp[2]), .out_data(o_data[2]), .out_tag(o_tag[2]));

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Reference arithmetic done in 64-bit space so carries and borrows are explicit.
  task automatic refCalc(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         output logic [1:0] r, output logic [31:0] d);
    longint unsigned a, b, s;
    a = 64'(op1);
    b = 64'(op2);
    r = RESP_INVL;
    d = 32'd0;
    if (cmd == CMD_ADD) begin
      s = a + b;
      if (s <= 64'hFFFF_FFFF) begin r = RESP_GOOD; d = 32'(s); end
    end else if (cmd == CMD_SUB) begin
      if (b <= a) begin r = RESP_GOOD; d = 32'(a - b); end
    end else if (cmd == CMD_LSH) begin
      r = RESP_GOOD;
      d = 32'(a << (op2 % 32));
    end else if (cmd == CMD_RSH) begin
      r = RESP_GOOD;
      d = 32'(a >> (op2 % 32));
    end
  endtask

  task automatic modelPush(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [1:0] tag);
    logic [1:0]  r;
    logic [31:0] d;
    bit          dup;
    int          t;
    refCalc(cmd, op1, op2, r, d);
    for (int k = 0; k < NDUT; k++) begin
      t   = cyc + LATS[k];
      dup = 0;
      for (int u = cyc + 1; u < t; u++) begin
        if (exp_resp[k][u] != RESP_NORE && exp_tag[k][u] == tag) dup = 1;
      end
      exp_resp[k][t] = dup ? RESP_ERR : r;
      exp_data[k][t] = dup ? 32'd0 : d;
      exp_tag[k][t]  = tag;
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NDUT; k++) begin
      for (int u = cyc; u < MAXC; u++) begin
        exp_resp[k][u] = RESP_NORE;
        exp_data[k][u] = 32'd0;
        exp_tag[k][u]  = 2'd0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] data, input logic [1:0] tag,
                       input logic rst);
    req_cmd_in  = cmd;
    req_data_in = data;
    req_tag_in  = tag;
    reset       = rst;
    @(posedge c_clk);
    cyc++;
  endtask

  task automatic checkOutput();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks += 3;
      assert (o_resp[k] === exp_resp[k][cyc]) else begin
        errors++;
        $error("[TB] FAIL lat%0d_resp cyc=%0d got=%0h exp=%0h", LATS[k], cyc, o_resp[k], exp_resp[k][cyc]);
      end
      assert (o_data[k] === exp_data[k][cyc]) else begin
        errors++;
        $error("[TB] FAIL lat%0d_data cyc=%0d got=%0h exp=%0h", LATS[k], cyc, o_data[k], exp_data[k][cyc]);
      end
      assert (o_tag[k] === exp_tag[k][cyc]) else begin
        errors++;
        $error("[TB] FAIL lat%0d_tag cyc=%0d got=%0h exp=%0h", LATS[k], cyc, o_tag[k], exp_tag[k][cyc]);
      end
    end
  endtask

  // Command cycle then operand-2 cycle; junk on cmd/tag during operand 2 must be ignored.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [1:0] tag,
                               input logic [31:0] op1, input logic [31:0] op2);
    drive(cmd, op1, tag, 1'b0);
    checkOutput();
    drive(4'($urandom), op2, 2'($urandom), 1'b0);
    modelPush(cmd, op1, op2, tag);
    checkOutput();
  endtask

  task automatic applyReset(input int n, input logic [3:0] cmd);
    for (int i = 0; i < n; i++) begin
      drive(cmd, $urandom, 2'($urandom), 1'b1);
      modelReset();
      checkOutput();
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(CMD_NOP, $urandom, 2'($urandom), 1'b0);
      checkOutput();
    end
  endtask

  task automatic applyAbort(input logic [3:0] cmd, input logic [1:0] tag,
                            input logic [31:0] op1, input logic [31:0] op2);
    drive(cmd, op1, tag, 1'b0);
    checkOutput();
    drive(4'($urandom), op2, 2'($urandom), 1'b1);
    modelReset();
    checkOutput();
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] a, b;
    int          sel;
    cyc    = 0;
    checks = 0;
    errors = 0;
    for (int k = 0; k < NDUT; k++) begin
      for (int u = 0; u < MAXC; u++) begin
        exp_resp[k][u] = RESP_NORE;
        exp_data[k][u] = 32'd0;
        exp_tag[k][u]  = 2'd0;
      end
    end
    $display("[TB] start");

    applyReset(2, CMD_ADD);

    applyStimulus(CMD_ADD, 2'd1, 32'd5, 32'd7);
    applyIdle(2);
    checks += 3;
    assert (o_resp[0] === RESP_GOOD) else begin
      errors++;
      $error("[TB] FAIL add5_7_resp got=%0h exp=%0h", o_resp[0], RESP_GOOD);
    end
    assert (o_data[0] === 32'd12) else begin
      errors++;
      $error("[TB] FAIL add5_7_data got=%0h exp=%0h", o_data[0], 32'd12);
    end
    assert (o_tag[0] === 2'd1) else begin
      errors++;
      $error("[TB] FAIL add5_7_tag got=%0h exp=%0h", o_tag[0], 2'd1);
    end
    applyIdle(8);

    applyStimulus(CMD_ADD, 2'd0, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(CMD_SUB, 2'd1, 32'd3, 32'd5);
    applyStimulus(CMD_SUB, 2'd2, 32'd5, 32'd5);
    applyStimulus(CMD_LSH, 2'd3, 32'd1, 32'h21);
    applyIdle(8);
    applyStimulus(CMD_RSH, 2'd0, 32'h8000_0000, 32'd31);
    applyStimulus(4'b1111, 2'd1, 32'd9, 32'd9);
    applyIdle(10);

    for (int i = 0; i < 4; i++) applyStimulus(CMD_ADD, 2'(i), $urandom_range(0, 1000), $urandom_range(0, 1000));
    applyIdle(10);

    applyStimulus(CMD_ADD, 2'd2, 32'd10, 32'd20);
    applyStimulus(CMD_SUB, 2'd2, 32'd9, 32'd4);
    applyIdle(10);

    applyStimulus(CMD_ADD, 2'd1, 32'd3, 32'd4);
    applyAbort(CMD_ADD, 2'd0, 32'd6, 32'd6);
    applyStimulus(CMD_ADD, 2'd3, 32'd1, 32'd1);
    applyIdle(10);

    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        applyReset($urandom_range(1, 2), 4'($urandom));
      end else if (sel == 1) begin
        applyAbort(CMD_SUB, 2'($urandom), $urandom, $urandom);
      end else begin
        case ($urandom_range(0, 4))
          0: rc = CMD_ADD;
          1: rc = CMD_SUB;
          2: rc = CMD_LSH;
          3: rc = CMD_RSH;
          default: rc = 4'($urandom_range(1, 15));
        endcase
        a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
        b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
        if ($urandom_range(0, 7) == 0) b = a;
        applyStimulus(rc, 2'($urandom), a, b);
        applyIdle($urandom_range(0, 2));
      end
    end
    applyIdle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
